// File: rtl/pong_ball_engine.sv
// Frame-rate ball physics and scoring for PingPong: advances the ball once per
// frameTick, resolves wall/paddle bounces, keeps the score and the serve/game phases.
module pong_ball_engine #(
   parameter int SCREEN_WIDTH  = 640,
   parameter int SCREEN_HEIGHT = 480,
   parameter int BALL_SIZE     = 8,
   parameter int PADDLE_WIDTH  = 10,
   parameter int PADDLE_HEIGHT = 100,
   parameter int SPEED_X       = 4,
   parameter int SPEED_Y       = 3,
   parameter int SERVE_FRAMES  = 60,
   parameter int WIN_SCORE     = 9
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        frameTick,
   input  logic        restart,
   input  logic [31:0] leftPaddle,
   input  logic [31:0] rightPaddle,
   output logic [31:0] ballPosition,
   output logic [3:0]  scoreLeft,
   output logic [3:0]  scoreRight,
   output logic        pointLeft,
   output logic        pointRight,
   output logic        paddleHit,
   output logic        gameOver
);

   localparam logic [1:0] ST_SERVE     = 2'd0;
   localparam logic [1:0] ST_PLAY      = 2'd1;
   localparam logic [1:0] ST_GAME_OVER = 2'd2;

   localparam logic signed [15:0] CX    = 16'((SCREEN_WIDTH - BALL_SIZE) / 2);
   localparam logic signed [15:0] CY    = 16'((SCREEN_HEIGHT - BALL_SIZE) / 2);
   localparam logic signed [15:0] MAX_X = 16'(SCREEN_WIDTH - BALL_SIZE);
   localparam logic signed [15:0] MAX_Y = 16'(SCREEN_HEIGHT - BALL_SIZE);
   localparam logic signed [15:0] BSZ   = 16'(BALL_SIZE);
   localparam logic signed [15:0] PW    = 16'(PADDLE_WIDTH);
   localparam logic signed [15:0] PH    = 16'(PADDLE_HEIGHT);
   localparam logic signed [15:0] SX    = 16'(SPEED_X);
   localparam logic signed [15:0] SY    = 16'(SPEED_Y);
   localparam logic [15:0]        SERVE_LAST = 16'(SERVE_FRAMES - 1);
   localparam logic [3:0]         WIN   = 4'(WIN_SCORE);

   logic [1:0]         state_r, state_s;
   logic signed [15:0] x_r, x_s, y_r, y_s, vx_r, vx_s, vy_r, vy_s;
   logic [15:0]        serve_cnt_r, serve_cnt_s;
   logic [3:0]         score_l_r, score_l_s, score_r_r, score_r_s;
   logic               point_l_r, point_l_s, point_r_r, point_r_s;
   logic               hit_r, hit_s, game_over_r, game_over_s;

   logic signed [15:0] lx_s, ly_s, rx_s, ry_s, nx_s, ny_s, lf_s;
   logic               l_hit_s, r_hit_s;

   assign lx_s = leftPaddle[31:16];
   assign ly_s = leftPaddle[15:0];
   assign rx_s = rightPaddle[31:16];
   assign ry_s = rightPaddle[15:0];
   assign nx_s = x_r + vx_r;
   assign ny_s = y_r + vy_r;
   assign lf_s = lx_s + PW;

   // Paddle contact is judged on the pre-move y so a ball grazing a corner is not caught late.
   assign l_hit_s = (vx_r < 16'sd0) && (x_r >= lf_s) && (nx_s <= lf_s) &&
                    (y_r + BSZ > ly_s) && (y_r < ly_s + PH);
   assign r_hit_s = (vx_r > 16'sd0) && (x_r + BSZ <= rx_s) && (nx_s + BSZ >= rx_s) &&
                    (y_r + BSZ > ry_s) && (y_r < ry_s + PH);

   // Next-state: restart first, then per-frame serve count / motion / scoring.
   always_comb begin
      state_s     = state_r;
      x_s         = x_r;
      y_s         = y_r;
      vx_s        = vx_r;
      vy_s        = vy_r;
      serve_cnt_s = serve_cnt_r;
      score_l_s   = score_l_r;
      score_r_s   = score_r_r;
      point_l_s   = 1'b0;
      point_r_s   = 1'b0;
      hit_s       = 1'b0;
      if (restart) begin
         state_s     = ST_SERVE;
         x_s         = CX;
         y_s         = CY;
         vx_s        = SX;
         vy_s        = SY;
         serve_cnt_s = 16'd0;
         score_l_s   = 4'd0;
         score_r_s   = 4'd0;
      end else if (frameTick) begin
         case (state_r)
            ST_SERVE: begin
               if (serve_cnt_r == SERVE_LAST) begin
                  state_s     = ST_PLAY;
                  serve_cnt_s = 16'd0;
               end else begin
                  serve_cnt_s = serve_cnt_r + 16'd1;
               end
            end
            ST_PLAY: begin
               if (ny_s <= 16'sd0) begin
                  y_s  = 16'sd0;
                  vy_s = SY;
               end else if (ny_s >= MAX_Y) begin
                  y_s  = MAX_Y;
                  vy_s = -SY;
               end else begin
                  y_s = ny_s;
               end
               if (l_hit_s) begin
                  x_s   = lf_s;
                  vx_s  = SX;
                  hit_s = 1'b1;
               end else if (r_hit_s) begin
                  x_s   = rx_s - BSZ;
                  vx_s  = -SX;
                  hit_s = 1'b1;
               end else if (nx_s <= 16'sd0) begin
                  score_r_s   = score_r_r + 4'd1;
                  point_r_s   = 1'b1;
                  x_s         = CX;
                  y_s         = CY;
                  vx_s        = -SX;
                  vy_s        = SY;
                  serve_cnt_s = 16'd0;
                  state_s     = (score_r_s == WIN) ? ST_GAME_OVER : ST_SERVE;
               end else if (nx_s >= MAX_X) begin
                  score_l_s   = score_l_r + 4'd1;
                  point_l_s   = 1'b1;
                  x_s         = CX;
                  y_s         = CY;
                  vx_s        = SX;
                  vy_s        = SY;
                  serve_cnt_s = 16'd0;
                  state_s     = (score_l_s == WIN) ? ST_GAME_OVER : ST_SERVE;
               end else begin
                  x_s = nx_s;
               end
            end
            ST_GAME_OVER: begin
               state_s = ST_GAME_OVER;
            end
            default: begin
               state_s = ST_SERVE;
            end
         endcase
      end else begin
         state_s = state_r;
      end
      game_over_s = (state_s == ST_GAME_OVER);
   end

   // State and output registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_r     <= ST_SERVE;
         x_r         <= CX;
         y_r         <= CY;
         vx_r        <= SX;
         vy_r        <= SY;
         serve_cnt_r <= 16'd0;
         score_l_r   <= 4'd0;
         score_r_r   <= 4'd0;
         point_l_r   <= 1'b0;
         point_r_r   <= 1'b0;
         hit_r       <= 1'b0;
         game_over_r <= 1'b0;
      end else begin
         state_r     <= state_s;
         x_r         <= x_s;
         y_r         <= y_s;
         vx_r        <= vx_s;
         vy_r        <= vy_s;
         serve_cnt_r <= serve_cnt_s;
         score_l_r   <= score_l_s;
         score_r_r   <= score_r_s;
         point_l_r   <= point_l_s;
         point_r_r   <= point_r_s;
         hit_r       <= hit_s;
         game_over_r <= game_over_s;
      end
   end

   assign ballPosition = {x_r, y_r};
   assign scoreLeft    = score_l_r;
   assign scoreRight   = score_r_r;
   assign pointLeft    = point_l_r;
   assign pointRight   = point_r_r;
   assign paddleHit    = hit_r;
   assign gameOver     = game_over_r;

endmodule

// File: tb/tb_pong_ball_engine.sv
// Self-checking bench for pong_ball_engine: serve table, directed rallies/misses/game over,
// reset priority, then randomized play against a frame-level reference model.
module tb_pong_ball_engine;

   localparam int W = 640, H = 480, B = 8, PW = 10, PH = 100;
   localparam int SX = 4, SY = 3, SF = 60, WIN = 9;
   localparam int CX = 316, CY = 236;

   logic        clk = 1'b0;
   logic        rst, frameTick, restart;
   logic [31:0] leftPaddle, rightPaddle, ballPosition;
   logic [3:0]  scoreLeft, scoreRight;
   logic        pointLeft, pointRight, paddleHit, gameOver;

   always #5 clk = ~clk;

   pong_ball_engine dut (
      .clk(clk), .rst(rst), .frameTick(frameTick), .restart(restart),
      .leftPaddle(leftPaddle), .rightPaddle(rightPaddle), .ballPosition(ballPosition),
      .scoreLeft(scoreLeft), .scoreRight(scoreRight), .pointLeft(pointLeft),
      .pointRight(pointRight), .paddleHit(paddleHit), .gameOver(gameOver)
   );

   typedef enum int {M_SERVE, M_PLAY, M_OVER} mphase_t;
   mphase_t m_phase;
   int m_x, m_y, m_vx, m_vy, m_frames, m_sl, m_sr;
   bit m_pl, m_pr, m_hit, m_hit_left;

   int n_checks = 0, n_pass = 0;
   int l_x, l_y, r_x, r_y;
   bit trk_l, trk_r;

   typedef struct { int ticks; int ex; int ey; } serve_vec_t;
   serve_vec_t tbl [6];

   task automatic chk(input string name, input longint act, input longint exp);
      n_checks++;
      if (act == exp) n_pass++;
      else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
   endtask

   function automatic int s16(input logic [15:0] v);
      return int'($signed(v));
   endfunction

   task automatic model_reset();
      m_phase = M_SERVE; m_x = CX; m_y = CY; m_vx = SX; m_vy = SY;
      m_frames = 0; m_sl = 0; m_sr = 0; m_pl = 0; m_pr = 0; m_hit = 0;
   endtask

   task automatic award(input bit left_scores);
      if (left_scores) begin m_sl++; m_pl = 1; m_vx = SX; end
      else begin m_sr++; m_pr = 1; m_vx = -SX; end
      m_x = CX; m_y = CY; m_vy = SY; m_frames = 0;
      m_phase = (m_sl == WIN || m_sr == WIN) ? M_OVER : M_SERVE;
   endtask

   // One clock edge of the reference game: what the ball should do this frame.
   task automatic model_clock(input bit tick, input bit rs, input int lx, input int ly,
                              input int rx, input int ry);
      int nx, ny;
      bit l_ok, r_ok;
      m_pl = 0; m_pr = 0; m_hit = 0;
      if (rs) begin
         model_reset();
      end else if (tick && m_phase == M_SERVE) begin
         m_frames++;
         if (m_frames == SF) begin m_phase = M_PLAY; m_frames = 0; end
      end else if (tick && m_phase == M_PLAY) begin
         nx = m_x + m_vx;
         ny = m_y + m_vy;
         l_ok = m_vx < 0 && m_x >= lx + PW && nx <= lx + PW && m_y + B > ly && m_y < ly + PH;
         r_ok = m_vx > 0 && m_x + B <= rx && nx + B >= rx && m_y + B > ry && m_y < ry + PH;
         if (ny <= 0) begin m_y = 0; m_vy = SY; end
         else if (ny >= H - B) begin m_y = H - B; m_vy = -SY; end
         else m_y = ny;
         if (l_ok) begin m_x = lx + PW; m_vx = SX; m_hit = 1; m_hit_left = 1; end
         else if (r_ok) begin m_x = rx - B; m_vx = -SX; m_hit = 1; m_hit_left = 0; end
         else if (nx <= 0) award(1'b0);
         else if (nx >= W - B) award(1'b1);
         else m_x = nx;
      end
   endtask

   task automatic check_model();
      logic [43:0] exp_v, act_v;
      exp_v = {16'(m_x), 16'(m_y), 4'(m_sl), 4'(m_sr), m_pl, m_pr, m_hit, (m_phase == M_OVER)};
      act_v = {ballPosition, scoreLeft, scoreRight, pointLeft, pointRight, paddleHit, gameOver};
      n_checks++;
      if (act_v == exp_v) n_pass++;
      else $display("FAIL model @%0t: got %h, expected %h (ball,sL,sR,pL,pR,hit,over)",
                    $time, act_v, exp_v);
   endtask

   task automatic step(input bit tick, input bit rs);
      if (trk_l) l_y = m_y - 46;
      if (trk_r) r_y = m_y - 46;
      frameTick   = tick;
      restart     = rs;
      leftPaddle  = {16'(l_x), 16'(l_y)};
      rightPaddle = {16'(r_x), 16'(r_y)};
      @(posedge clk);
      model_clock(tick, rs, l_x, l_y, r_x, r_y);
      #1;
      frameTick = 1'b0;
      restart   = 1'b0;
      check_model();
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      bit top_done;
      top_done = 0;
      tbl[0] = '{1,  316, 236};
      tbl[1] = '{58, 316, 236};
      tbl[2] = '{1,  316, 236};
      tbl[3] = '{1,  320, 239};
      tbl[4] = '{1,  324, 242};
      tbl[5] = '{3,  336, 251};

      rst = 1'b1; frameTick = 1'b0; restart = 1'b0;
      l_x = 15; l_y = 0; r_x = 615; r_y = 0; trk_l = 1; trk_r = 1;
      leftPaddle = 32'd0; rightPaddle = 32'd0;
      model_reset();
      repeat (3) @(posedge clk);
      #1;
      chk("reset_ball", ballPosition, {16'd316, 16'd236});
      chk("reset_scores", {scoreLeft, scoreRight}, 0);
      chk("reset_pulses", {pointLeft, pointRight, paddleHit, gameOver}, 0);
      @(negedge clk);
      rst = 1'b0;

      // Serve timing: 60 ticks at centre, the 61st moves the ball.
      for (int i = 0; i < 6; i++) begin
         for (int k = 0; k < tbl[i].ticks; k++) begin
            step(1'b1, 1'b0);
            step(1'b0, 1'b0);
         end
         chk($sformatf("serve_tbl%0d_x", i), ballPosition[31:16], tbl[i].ex);
         chk($sformatf("serve_tbl%0d_y", i), ballPosition[15:0], tbl[i].ey);
      end

      // Rally with both paddles tracking: wall and paddle bounces, no score.
      for (int i = 0; i < 800; i++) begin
         step(1'b1, 1'b0);
         if (m_hit) begin
            chk("paddle_hit_pulse", paddleHit, 1);
            chk("paddle_face_x", ballPosition[31:16], m_hit_left ? 25 : 607);
         end
         if (m_y == 0 && !top_done) begin
            top_done = 1;
            chk("top_wall_y0", s16(ballPosition[15:0]), 0);
            step(1'b1, 1'b0);
            chk("top_wall_y3", s16(ballPosition[15:0]), 3);
         end
      end
      chk("rally_no_score", {scoreLeft, scoreRight}, 0);

      // Left player misses: right scores, next serve goes left.
      trk_l = 0; l_y = -200;
      for (int i = 0; i < 500 && !m_pr; i++) step(1'b1, 1'b0);
      chk("miss_point_right", pointRight, 1);
      chk("miss_score_right", scoreRight, 1);
      chk("miss_ball_centre", ballPosition, {16'd316, 16'd236});
      for (int i = 0; i < 60; i++) step(1'b1, 1'b0);
      chk("miss_serve_hold", ballPosition, {16'd316, 16'd236});
      step(1'b1, 1'b0);
      chk("miss_serve_left", ballPosition, {16'd312, 16'd239});
      repeat (5) step(1'b1, 1'b0);

      // Asynchronous reset mid-PLAY, between clock edges.
      @(negedge clk);
      #2;
      rst = 1'b1;
      #1;
      chk("async_rst_ball", ballPosition, {16'd316, 16'd236});
      chk("async_rst_scores", {scoreLeft, scoreRight}, 0);
      chk("async_rst_flags", {pointLeft, pointRight, paddleHit, gameOver}, 0);
      model_reset();
      @(negedge clk);
      rst = 1'b0;

      // Nine right-player points end the game.
      for (int i = 0; i < 3000 && m_phase != M_OVER; i++) step(1'b1, 1'b0);
      chk("go_game_over", gameOver, 1);
      chk("go_point_right", pointRight, 1);
      chk("go_score_right", scoreRight, 9);
      repeat (5) step(1'b1, 1'b0);
      chk("go_ball_frozen", ballPosition, {16'd316, 16'd236});
      chk("go_still_over", gameOver, 1);
      step(1'b0, 1'b1);
      chk("restart_scores", {scoreLeft, scoreRight}, 0);
      chk("restart_not_over", gameOver, 0);
      for (int i = 0; i < 61; i++) step(1'b1, 1'b0);
      chk("restart_serve_right", ballPosition, {16'd320, 16'd239});

      // restart coincident with frameTick in PLAY wins.
      repeat (3) step(1'b1, 1'b0);
      step(1'b1, 1'b1);
      chk("restart_tick_centre", ballPosition, {16'd316, 16'd236});
      step(1'b1, 1'b0);
      chk("restart_tick_hold", ballPosition, {16'd316, 16'd236});

      // Randomized play against the model.
      trk_l = 0; trk_r = 0;
      for (int i = 0; i < 12000; i++) begin
         bit tk, rs;
         tk = 1'($urandom_range(0, 1));
         rs = (m_phase == M_OVER) ? ($urandom_range(0, 19) == 0) : ($urandom_range(0, 499) == 0);
         l_x = int'($urandom_range(0, 40));
         r_x = 590 + int'($urandom_range(0, 40));
         l_y = m_y - 46 + int'($urandom_range(0, 140)) - 70;
         r_y = m_y - 46 + int'($urandom_range(0, 140)) - 70;
         step(tk, rs);
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
